muldiv_ctrl: RTL and testbench

Multi-cycle RV32M multiply/divide unit and its sequencer, sitting beside the ALU in the execute stage. It accepts one operation per start pulse, iterates a shared shift-add / restoring-divide datapath for 32 cycles, and holds the pipeline with `stall_o` until the result is ready. The result is presented for exactly one cycle on `done_o`, alongside the destination register tag.

---
 rtl/muldiv_ctrl.sv | 102 ++++++++++
 tb/tb_muldiv_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle RV32M multiply/divide unit with pipeline stall sequencing
module muldiv_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] srcA_i,
    input  logic [DATA_WIDTH-1:0] srcB_i,
    input  logic [4:0]            RdE_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            RdM_o
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_n;
    logic [5:0] cnt;
    logic [2:0] f3;
    logic neg, a_s, b_s, sa, sb, div0, ovf, special, accept;
    logic [W-1:0] m, lo, lo_n, a_mag, b_mag, dsel, fix, special_res;
    logic [W:0] acc, acc_n, mul_sum, div_sh, div_diff;
    logic [2*W-1:0] prod, prod_s;
    // Operand decode: signedness, magnitudes and the two divide shortcuts
    always_comb begin
        a_s = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
        b_s = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
        sa = a_s & srcA_i[W-1];
        sb = b_s & srcB_i[W-1];
        a_mag = sa ? -srcA_i : srcA_i;
        b_mag = sb ? -srcB_i : srcB_i;
        div0 = funct3_i[2] & (srcB_i == '0);
        ovf = funct3_i[2] & ~funct3_i[0] & (srcA_i == MIN) & (&srcB_i);
        special = div0 | ovf;
        special_res = div0 ? (funct3_i[1] ? srcA_i : '1) : (funct3_i[1] ? '0 : MIN);
        accept = (state == IDLE) & start_i & ~flush_i;
    end
    // Shared datapath step and final sign fix-up on the post-step values
    always_comb begin
        mul_sum = {1'b0, acc[W-1:0]} + (lo[0] ? {1'b0, m} : '0);
        div_sh = {acc[W-1:0], lo[W-1]};
        div_diff = div_sh - {1'b0, m};
        acc_n = (state == MUL) ? {1'b0, mul_sum[W:1]} : (div_diff[W] ? div_sh : div_diff);
        lo_n = (state == MUL) ? {mul_sum[0], lo[W-1:1]} : {lo[W-2:0], ~div_diff[W]};
        prod = {acc_n[W-1:0], lo_n};
        prod_s = neg ? -prod : prod;
        dsel = f3[1] ? acc_n[W-1:0] : lo_n;
        fix = f3[2] ? (neg ? -dsel : dsel) : ((f3 == 3'b000) ? prod_s[W-1:0] : prod_s[2*W-1:W]);
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // Next state and handshake outputs
    always_comb begin
        state_n = state;
        busy_o = state != IDLE;
        stall_o = accept | (state == MUL) | (state == DIV);
        done_o = (state == DONE) & ~flush_i;
        case (state)
            IDLE: if (accept) state_n = special ? DONE : (funct3_i[2] ? DIV : MUL);
            MUL, DIV: state_n = flush_i ? IDLE : ((cnt == 6'(W-1)) ? DONE : state);
            default: state_n = IDLE;
        endcase
    end
    // Operand capture, iteration and registered result (non-zero only in DONE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            f3 <= '0;
            neg <= 1'b0;
            m <= '0;
            lo <= '0;
            acc <= '0;
            result_o <= '0;
            RdM_o <= '0;
        end else begin
            result_o <= '0;
            if (accept) begin
                f3 <= funct3_i;
                RdM_o <= RdE_i;
                neg <= (funct3_i[2] & funct3_i[1]) ? sa : sa ^ sb;
                cnt <= '0;
                acc <= '0;
                m <= funct3_i[2] ? b_mag : a_mag;
                lo <= funct3_i[2] ? a_mag : b_mag;
                if (special) result_o <= special_res;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 6'd1;
                acc <= acc_n;
                lo <= lo_n;
                if (state_n == DONE) result_o <= fix;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vector bench for muldiv_ctrl plus flush/reset/back-to-back sequences
module tb_muldiv_ctrl;
    logic clk = 0, rst = 1, start = 0, flush = 0;
    logic [2:0] funct3 = 0;
    logic [31:0] src_a = 0, src_b = 0, result;
    logic [4:0] rd = 0, rdm;
    logic busy, stall, done;
    int total = 0, pass = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[16];

    muldiv_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .funct3_i(funct3),
        .srcA_i(src_a), .srcB_i(src_b), .RdE_i(rd), .flush_i(flush),
        .busy_o(busy), .stall_o(stall), .done_o(done),
        .result_o(result), .RdM_o(rdm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat, st;
        logic saw;
        logic [31:0] res;
        logic [4:0] tag;
        logic stall_done;
        @(negedge clk);
        start = 1; funct3 = v.f3; src_a = v.a; src_b = v.b; rd = v.rd;
        #1 st = stall ? 1 : 0;
        @(negedge clk);
        start = 0; funct3 = 0; src_a = 0; src_b = 0; rd = 0;
        lat = 1; saw = 0; res = 0; tag = 0; stall_done = 1;
        while (!saw && lat <= 40) begin
            #1;
            if (done) begin
                saw = 1; res = result; tag = rdm; stall_done = stall;
            end else begin
                if (stall) st++;
                lat++;
                @(negedge clk);
            end
        end
        check({name, " latency"}, lat, v.lat);
        check({name, " result"}, res, v.exp);
        check({name, " tag"}, {27'd0, tag}, {27'd0, v.rd});
        check({name, " stall cycles"}, st, v.lat);
        check({name, " stall in done"}, {31'd0, stall_done}, 32'd0);
        @(negedge clk);
        #1 check({name, " done pulse/idle"}, {29'd0, done, busy, result != 0}, 32'd0);
    endtask

    initial begin
        int n, first, second;
        logic [31:0] r1;
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1};
        vecs[12] = '{3'b000, 32'h12345678, 32'h10,       5'd17, 32'h23456780, 33};
        vecs[13] = '{3'b100, 32'd100,      32'hFFFFFFF9, 5'd18, 32'hFFFFFFF2, 33};
        vecs[14] = '{3'b110, 32'd100,      32'hFFFFFFF9, 5'd19, 32'd2,        33};
        vecs[15] = '{3'b001, 32'hFFFFFFFF, 32'd1,        5'd20, 32'hFFFFFFFF, 33};

        repeat (3) @(negedge clk);
        #1 check("reset flags", {29'd0, busy, stall, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset tag", {27'd0, rdm}, 32'd0);
        rst = 0;

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

        // flush during iteration 10
        @(negedge clk);
        start = 1; funct3 = 3'b000; src_a = 32'd7; src_b = 32'd3; rd = 5'd3;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1 check("flush idle", {29'd0, busy, stall, done}, 32'd0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("flush no done", n, 0);
        run_op("after flush", vecs[6]);

        // start and flush together in IDLE
        @(negedge clk);
        start = 1; flush = 1; funct3 = 3'b101; src_a = 32'd9; src_b = 32'd3;
        #1 check("start+flush stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 0; flush = 0;
        #1 check("start+flush busy", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-DIV
        @(negedge clk);
        start = 1; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7; rd = 5'd22;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1 check("rst flags", {29'd0, busy, stall, done}, 32'd0);
        check("rst tag", {27'd0, rdm}, 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        rst = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("rst no done", n, 0);

        // start held high continuously
        @(negedge clk);
        start = 1; funct3 = 3'b011; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; rd = 5'd21;
        n = 0; first = 0; second = 0; r1 = 0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (done) begin
                n++;
                if (n == 1) begin first = k; r1 = result; end
                else if (n == 2) second = k;
            end
        end
        start = 0;
        check("b2b count", n, 3);
        check("b2b first", first, 33);
        check("b2b gap", second - first, 34);
        check("b2b result", r1, 32'hFFFFFFFE);
        flush = 1;
        @(negedge clk);
        flush = 0;
        run_op("after b2b", vecs[0]);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
